// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port front end for a single-port data ram
module ram_arbiter #(
    parameter int N       = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  ctrl0,
    input  logic [1:0]  ctrl1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        ram_we,
    output logic [1:0]  ram_ctrl,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam logic [1:0] STORE_B  = 2'd0;
    localparam logic [1:0] STORE_HW = 2'd1;
    localparam logic [1:0] STORE_W  = 2'd2;

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t      state;
    logic        prio;
    logic        owner;
    logic [31:0] rd_addr;
    logic        win;
    logic        w_we;
    logic [1:0]  w_ctrl;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        bad;
    logic        grant;

    // pick the winning port and present its access to the ram
    always_comb begin
        win       = (req0 && req1) ? prio : req1;
        w_we      = win ? we1 : we0;
        w_ctrl    = win ? ctrl1 : ctrl0;
        w_addr    = win ? addr1 : addr0;
        w_wdata   = win ? wdata1 : wdata0;
        bad       = (w_ctrl == STORE_HW && w_addr[1:0] == 2'd3) ||
                    (w_ctrl == STORE_W && w_addr[1:0] != 2'd0) ||
                    (|w_addr[31:N+2]);
        grant     = rst_n && state == IDLE && (req0 || req1);
        gnt0      = grant && !win;
        gnt1      = grant && win;
        ram_we    = grant && w_we && !bad;
        ram_ctrl  = grant ? w_ctrl : STORE_B;
        ram_wdata = grant ? w_wdata : 32'd0;
        ram_addr  = grant ? w_addr : (rst_n && state == RD) ? rd_addr : 32'd0;
    end

    // sequence loads through RD/RESP and register the per-port responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= RR_INIT;
            owner   <= 1'b0;
            rd_addr <= 32'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= 32'd0;
            rdata1  <= 32'd0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= grant && bad && !win;
            err1    <= grant && bad && win;
            case (state)
                IDLE: begin
                    if (grant) begin
                        prio  <= !win;
                        owner <= win;
                        if (!bad && !w_we) begin
                            rd_addr <= w_addr;
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    rvalid0 <= !owner;
                    rvalid1 <= owner;
                    if (owner) rdata1 <= ram_rdata;
                    else rdata0 <= ram_rdata;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
